pwm_note_decoder: RTL and testbench

Receive-side counterpart of the player's tone output. Measures the period of an incoming square/PWM tone on a Pmod pin and decodes it back into the same 14-bit key vector the player consumes: bit0 = 494 Hz through bit13 = 131 Hz. Used for loopback self-test of the player and for recording played notes. Sits between a Pmod input pin and any key-vector consumer.

---
 rtl/note_pkg.sv | 9 +
 rtl/pwm_period_meter.sv | 48 ++++
 rtl/pwm_note_decoder.sv | 105 ++++++++++
 tb/tb_pwm_note_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// note_pkg: key frequency table, period helper and FSM states shared by the tone player and decoder.
package note_pkg;
  localparam int NUM_KEYS = 14;
  localparam int FREQS [NUM_KEYS] = '{494, 440, 392, 349, 329, 294, 262, 247, 220, 196, 175, 165, 147, 131};
  typedef enum logic [1:0] {IDLE, MEAS, LOCKED} state_e;
  function automatic int period_of(input int clk_hz, input int f);
    return clk_hz / f;
  endfunction
endpackage

// File: rtl/pwm_period_meter.sv
// pwm_period_meter: synchronizes the tone pin, detects rising edges and counts the cycles between them.
// NOTE_DEC_GLITCH_FILTER_EN adds a 4-cycle stability filter after the synchronizer.
module pwm_period_meter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_i,
  output logic             edge_o,
  output logic [CNT_W-1:0] period_o,
  output logic             timeout_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [1:0] sync_q;
  logic lvl, lvl_q, edge_q;
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) sync_q <= rst ? 2'b00 : {sync_q[0], pwm_i};
`ifdef NOTE_DEC_GLITCH_FILTER_EN
  logic filt_q;
  logic [1:0] stab_q;
  always_ff @(posedge clk)
    if (rst) begin
      filt_q <= 1'b0;
      stab_q <= 2'd0;
    end else if (sync_q[1] == filt_q) stab_q <= 2'd0;
    else if (stab_q == 2'd3) begin
      filt_q <= sync_q[1];
      stab_q <= 2'd0;
    end else stab_q <= stab_q + 2'd1;
  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif
  // cnt_q holds the cycle distance since the last edge pulse, so it is the period when edge_q fires
  always_ff @(posedge clk)
    if (rst) begin
      lvl_q  <= 1'b0;
      edge_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lvl_q  <= lvl;
      edge_q <= lvl & ~lvl_q;
      cnt_q  <= edge_q ? CNT_W'(1) : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
    end
  assign edge_o    = edge_q;
  assign period_o  = cnt_q;
  assign timeout_o = cnt_q == CNT_MAX;
endmodule

// File: rtl/pwm_note_decoder.sv
// pwm_note_decoder: decodes the period of an incoming tone into a one-hot 14-key vector.
module pwm_note_decoder import note_pkg::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 20,
  parameter int LOCK_N = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [NUM_KEYS-1:0] keys,
  output logic                key_valid,
  output logic [3:0]          key_idx,
  output logic                new_key
);
  localparam int RUN_W = $clog2(LOCK_N + 1);
  logic edge_w, timeout_w;
  logic [CNT_W-1:0] period_w;
  logic [31:0] per;
  logic [NUM_KEYS-1:0] in_win;
  logic hit;
  logic [3:0] hit_idx;
  state_e state_q, state_d;
  logic [3:0] cand_q, cand_d, idx_q, idx_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic valid_q, valid_d, new_q, new_d;
  pwm_period_meter #(.CNT_W(CNT_W)) u_meter (
    .clk      (clk),
    .rst      (reset),
    .pwm_i    (pwm_in),
    .edge_o   (edge_w),
    .period_o (period_w),
    .timeout_o(timeout_w)
  );
  assign per = 32'(period_w);
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_win
    localparam int PK = period_of(CLK_HZ, FREQS[k]);
    assign in_win[k] = per >= 32'(PK - (PK >> 6)) && per <= 32'(PK + (PK >> 6));
  end
  always_comb begin
    hit = 1'b0;
    hit_idx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (in_win[i]) begin
        hit = 1'b1;
        hit_idx = 4'(i);
      end
  end
  // an edge outranks a same-cycle timeout; a saturated period simply fails every window
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    keys_d  = keys_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    new_d   = 1'b0;
    if (edge_w) begin
      if (state_q == IDLE) state_d = MEAS;
      else if (!(state_q == LOCKED && hit && hit_idx == cand_q)) begin
        cand_d  = hit ? hit_idx : cand_q;
        run_d   = !hit ? '0 : (hit_idx == cand_q ? run_q + 1'b1 : RUN_W'(1));
        keys_d  = '0;
        idx_d   = 4'd0;
        valid_d = 1'b0;
        state_d = MEAS;
        if (run_d == RUN_W'(LOCK_N)) begin
          keys_d  = NUM_KEYS'(1) << cand_d;
          idx_d   = cand_d;
          valid_d = 1'b1;
          new_d   = 1'b1;
          state_d = LOCKED;
        end
      end
    end else if (timeout_w) begin
      state_d = IDLE;
      run_d   = '0;
      keys_d  = '0;
      idx_d   = 4'd0;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      run_q   <= '0;
      keys_q  <= '0;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      keys_q  <= keys_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      new_q   <= new_d;
    end
  assign keys      = keys_q;
  assign key_valid = valid_q;
  assign key_idx   = idx_q;
  assign new_key   = new_q;
endmodule

// File: tb/tb_pwm_note_decoder.sv
// tb_pwm_note_decoder: directed tone stimulus with a lock-event scoreboard, scaled to a 100 kHz clock table.
module tb_pwm_note_decoder;
  import note_pkg::*;
  localparam int CLK_HZ = 100_000;
  localparam int CNT_W  = 10;
  localparam int LOCK_N = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef NOTE_DEC_GLITCH_FILTER_EN
  localparam int LAT  = 7;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0, reset, pwm_in;
  logic [NUM_KEYS-1:0] keys;
  logic key_valid, new_key;
  logic [3:0] key_idx;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [13:0] keys; logic [3:0] idx;} exp_t;
  exp_t exp_q[$];
  int bp [4] = '{205, 206, 199, 198};
  bit acc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  pwm_note_decoder #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .pwm_in   (pwm_in),
    .keys     (keys),
    .key_valid(key_valid),
    .key_idx  (key_idx),
    .new_key  (new_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tone(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      wait_n(per / 2);
      pwm_in = 1'b0;
      wait_n(per - per / 2);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (new_key === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_new_key", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("sb_keys", 32'(keys), 32'(e.keys));
        check("sb_idx", 32'(key_idx), 32'(e.idx));
        check("sb_valid", 32'(key_valid), 32'd1);
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pwm_in = 1'b0;
    wait_n(5);
    check("rst_keys", 32'(keys), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_idx", 32'(key_idx), 32'd0);
    check("rst_new_key", 32'(new_key), 32'd0);
    reset = 1'b0;
    wait_n(2);
    // 440 Hz: lock exactly LAT+1 clk after the 4th rising edge
    exp_q.push_back('{14'h0002, 4'd1});
    tone(227, 3);
    pwm_in = 1'b1;
    wait_n(LAT);
    check("a_prelock", 32'(keys), 32'd0);
    wait_n(1);
    check("a_keys", 32'(keys), 32'h2);
    check("a_idx", 32'(key_idx), 32'd1);
    check("a_valid", 32'(key_valid), 32'd1);
    check("a_new_key", 32'(new_key), 32'd1);
    wait_n(1);
    check("a_new_key_pulse", 32'(new_key), 32'd0);
    wait_n(113 - LAT - 2);
    pwm_in = 1'b0;
    wait_n(114);
    tone(227, 2);
    check("a_hold", 32'(keys), 32'h2);
    exp_q.push_back('{14'h0001, 4'd0});
    tone(202, 6);
    check("b_keys494", 32'(keys), 32'h1);
    // switch to 131 Hz: release on the first long period's closing edge
    tone(763, 1);
    pwm_in = 1'b1;
    wait_n(LAT);
    check("c_hold", 32'(keys), 32'h1);
    wait_n(1);
    check("c_release_keys", 32'(keys), 32'd0);
    check("c_release_valid", 32'(key_valid), 32'd0);
    check("c_release_idx", 32'(key_idx), 32'd0);
    wait_n(381 - LAT - 1);
    pwm_in = 1'b0;
    wait_n(382);
    exp_q.push_back('{14'h2000, 4'd13});
    tone(763, 2);
    check("c_keys763", 32'(keys), 32'h2000);
    pwm_in = 1'b1;
    wait_n(381);
    pwm_in = 1'b0;
    wait_n(LAT + CMAX - 381);
    check("d_pre_timeout", 32'(keys), 32'h2000);
    wait_n(1);
    check("d_timeout_keys", 32'(keys), 32'd0);
    check("d_timeout_idle", 32'(dut.state_q), 32'(IDLE));
    exp_q.push_back('{14'h0040, 4'd6});
    tone(381, 5);
    check("d_relock", 32'(keys), 32'h40);
    pwm_in = 1'b1;
    wait_n(100);
    reset = 1'b1;
    wait_n(1);
    check("e_rst_keys", 32'(keys), 32'd0);
    check("e_rst_valid", 32'(key_valid), 32'd0);
    check("e_rst_idx", 32'(key_idx), 32'd0);
    check("e_rst_new_key", 32'(new_key), 32'd0);
    pwm_in = 1'b0;
    wait_n(2);
    reset = 1'b0;
    check("e_rst_idle", 32'(dut.state_q), 32'(IDLE));
    exp_q.push_back('{14'h0040, 4'd6});
    tone(381, 5);
    check("e_relock", 32'(keys), 32'h40);
    for (int i = 0; i < 4; i++) begin
      wait_n(1100);
      check($sformatf("f_idle_%0d", bp[i]), 32'(keys), 32'd0);
      if (acc[i]) exp_q.push_back('{14'h0001, 4'd0});
      tone(bp[i], 6);
      check($sformatf("f_window_%0d", bp[i]), 32'(keys), acc[i] ? 32'h1 : 32'h0);
    end
    // 262 Hz with a 2-cycle high glitch inside every low phase
    wait_n(1100);
    if (FILT) exp_q.push_back('{14'h0040, 4'd6});
    for (int i = 0; i < 8; i++) begin
      pwm_in = 1'b1;
      wait_n(190);
      pwm_in = 1'b0;
      wait_n(100);
      pwm_in = 1'b1;
      wait_n(2);
      pwm_in = 1'b0;
      wait_n(89);
    end
    check("g_glitch", 32'(keys), FILT ? 32'h40 : 32'h0);
    wait_n(5);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
